// File: rtl/reset_seq_sync.sv
// reset_seq_sync
//   Multi-channel reset synchroniser and sequencer. An asynchronous active-low
//   board reset asserts every output at once, with no clock needed. Its release
//   is synchronised to clk. After a minimum hold time, the channel resets are
//   released one at a time in index order, with a fixed gap between releases.
//   A synchronous soft-reset request re-runs the hold/release sequence without
//   a board reset.
//
// Ports
//   clk           system clock
//   rst_in        board reset, asynchronous assert, active-low
//   soft_rst_req  synchronous soft-reset request (level or pulse)
//   rst_out       per-channel reset, bit i released i-th, active at OUT_ACTIVE_LEVEL
//   rst_done      high once every channel is released
//   busy          high while any channel is still asserted (~rst_done)
//
// All outputs are registered; no input reaches an output combinationally.

module reset_seq_sync #(
    parameter int   SYNC_STAGE       = 3,
    parameter int   CHANNELS         = 4,
    parameter int   MIN_ASSERT       = 8,
    parameter int   RELEASE_GAP      = 16,
    parameter logic OUT_ACTIVE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                soft_rst_req,
    output logic [CHANNELS-1:0] rst_out,
    output logic                rst_done,
    output logic                busy
);

    localparam int CNT_MAX = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {SYNC, HOLD, RELEASE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SYNC_STAGE-1:0] sync_q;
    logic                  sync_ok;
    logic                  rel_now;   // release channel idx_q on this edge
    logic                  restart;   // soft reset sampled on this edge
    logic [CHANNELS-1:0]   out_d;
    logic                  done_d;

    // Release synchroniser: shifts in ones once rst_in is high.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGE-2:0], 1'b1};
    end

    assign sync_ok = sync_q[SYNC_STAGE-1];

    // State register plus the registered outputs.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= SYNC;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_out  <= {CHANNELS{OUT_ACTIVE_LEVEL}};
            rst_done <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_out  <= out_d;
            rst_done <= done_d;
            busy     <= ~done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_now = 1'b0;
        restart = 1'b0;
        case (state_q)
            // The edge that first sees sync_ok already counts as hold cycle 1,
            // so HOLD is entered one count ahead. With a one-cycle hold,
            // channel 0 is released on that same edge.
            SYNC: begin
                if (sync_ok) begin
                    if (MIN_ASSERT == 1) begin
                        rel_now = 1'b1;
                        idx_d   = IW'(1);
                        cnt_d   = CW'(1);
                        state_d = (CHANNELS == 1) ? DONE : RELEASE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = CW'(2);
                    end
                end
            end
            HOLD: begin
                if (soft_rst_req) begin
                    restart = 1'b1;
                end else if (cnt_q == CW'(MIN_ASSERT)) begin
                    rel_now = 1'b1;
                    idx_d   = IW'(1);
                    cnt_d   = CW'(1);
                    state_d = (CHANNELS == 1) ? DONE : RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (soft_rst_req) begin
                    restart = 1'b1;
                end else if (cnt_q == CW'(RELEASE_GAP)) begin
                    rel_now = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = CW'(1);
                    if (idx_q == IW'(CHANNELS - 1)) state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // cnt and idx hold their final values here.
                if (soft_rst_req) restart = 1'b1;
            end
            default: state_d = SYNC;
        endcase
        if (restart) begin
            state_d = HOLD;
            cnt_d   = CW'(1);
            idx_d   = '0;
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        out_d  = rst_out;
        done_d = rst_done;
        if (restart) begin
            out_d  = {CHANNELS{OUT_ACTIVE_LEVEL}};
            done_d = 1'b0;
        end else if (rel_now) begin
            for (int i = 0; i < CHANNELS; i++)
                if (idx_q == IW'(i)) out_d[i] = ~OUT_ACTIVE_LEVEL;
            if (idx_q == IW'(CHANNELS - 1)) done_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_reset_seq_sync.sv
// Bench for reset_seq_sync: a default instance (a) and a minimal instance (b:
// SYNC_STAGE=2, CHANNELS=1, MIN_ASSERT=1, OUT_ACTIVE_LEVEL=0) share clk and
// rst_in. The reference model does not track FSM states. It keeps one
// "sequence base" edge per instance. Channel i is released once the current
// edge count reaches base + MIN_ASSERT + i*RELEASE_GAP.
module tb_reset_seq_sync;

    localparam longint BIG = 64'h100_0000_0000;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       soft_a = 1'b0, soft_b = 1'b0;
    logic [3:0] out_a;
    logic       done_a, busy_a;
    logic [0:0] out_b;
    logic       done_b, busy_b;

    int     checks = 0, fails = 0;
    longint n = 0;                      // posedges seen so far
    longint base_a = BIG, base_b = BIG; // sequence base edge
    longint sync_a = BIG, sync_b = BIG; // first edge a soft request is honoured
    logic [3:0] ra, rb;

    reset_seq_sync dut_a (
        .clk(clk), .rst_in(rst_in), .soft_rst_req(soft_a),
        .rst_out(out_a), .rst_done(done_a), .busy(busy_a)
    );

    reset_seq_sync #(
        .SYNC_STAGE(2), .CHANNELS(1), .MIN_ASSERT(1), .RELEASE_GAP(1),
        .OUT_ACTIVE_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst_in(rst_in), .soft_rst_req(soft_b),
        .rst_out(out_b), .rst_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Reference model.
    always @(posedge clk) begin
        n = n + 1;
        if (rst_in === 1'b1) begin
            if (soft_a && n >= sync_a) base_a = n;
            if (soft_b && n >= sync_b) base_b = n;
        end
    end

    always @(negedge rst_in) begin
        base_a = BIG; sync_a = BIG;
        base_b = BIG; sync_b = BIG;
    end

    // Edge n+1 is edge 1 after the rise. The synchroniser completes at edge
    // n+S. A soft request is honoured from edge n+S+2 onward.
    always @(posedge rst_in) begin
        base_a = n + 3; sync_a = n + 5;
        base_b = n + 2; sync_b = n + 4;
    end

    function automatic logic [3:0] rel_vec(longint now, longint base, int c, int m, int g);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < c; i++) r[i] = (now >= base + m + i * g);
        return r;
    endfunction

    task automatic test_reset();
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        #1;
        checks++;
        if ({out_a, done_a, busy_a} !== 6'b1111_01) begin
            fails++; $display("FAIL reset_a: got %b want %b", {out_a, done_a, busy_a}, 6'b1111_01);
        end
        checks++;
        if ({out_b, done_b, busy_b} !== 3'b0_0_1) begin
            fails++; $display("FAIL reset_b: got %b want %b", {out_b, done_b, busy_b}, 3'b001);
        end
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            @(negedge clk);
            ra = rel_vec(n, base_a, 4, 8, 16);
            rb = rel_vec(n, base_b, 1, 1, 1);
            checks++;
            if ({out_a, done_a, busy_a} !== {~ra, &ra, ~&ra}) begin
                fails++; $display("FAIL seq_a edge %0d: got %b want %b", e, {out_a, done_a, busy_a}, {~ra, &ra, ~&ra});
            end
            checks++;
            if ({out_b, done_b, busy_b} !== {rb[0], rb[0], ~rb[0]}) begin
                fails++; $display("FAIL seq_b edge %0d: got %b want %b", e, {out_b, done_b, busy_b}, {rb[0], rb[0], ~rb[0]});
            end
            if (e == 10 || e == 11 || e == 27 || e == 43 || e == 58 || e == 59) begin
                logic [5:0] lit;
                case (e)
                    10:      lit = 6'b1111_01;
                    11:      lit = 6'b1110_01;
                    27:      lit = 6'b1100_01;
                    43:      lit = 6'b1000_01;
                    58:      lit = 6'b1000_01;
                    default: lit = 6'b0000_10;
                endcase
                checks++;
                if ({out_a, done_a, busy_a} !== lit) begin
                    fails++; $display("FAIL edge_lit_a edge %0d: got %b want %b", e, {out_a, done_a, busy_a}, lit);
                end
            end
            if (e == 2 || e == 3) begin
                checks++;
                if ({out_b, done_b} !== ((e == 3) ? 2'b11 : 2'b00)) begin
                    fails++; $display("FAIL edge_lit_b edge %0d: got %b", e, {out_b, done_b});
                end
            end
        end
    endtask

    task automatic test_async_in_done();
        @(negedge clk);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({out_a, done_a, busy_a, out_b, done_b, busy_b} !== 9'b1111_01_001) begin
            fails++; $display("FAIL async_done: got %b want %b", {out_a, done_a, busy_a, out_b, done_b, busy_b}, 9'b111101001);
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_in = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            @(negedge clk);
            ra = rel_vec(n, base_a, 4, 8, 16);
            rb = rel_vec(n, base_b, 1, 1, 1);
            checks++;
            if ({out_a, done_a, busy_a, out_b, done_b, busy_b} !== {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]}) begin
                fails++; $display("FAIL async_restart edge %0d: got %b want %b", e,
                    {out_a, done_a, busy_a, out_b, done_b, busy_b}, {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]});
            end
            if (e == 11 || e == 59) begin
                checks++;
                if (out_a !== ((e == 11) ? 4'b1110 : 4'b0000)) begin
                    fails++; $display("FAIL async_lit edge %0d: got %b", e, out_a);
                end
            end
        end
    endtask

    task automatic test_soft_done();
        @(negedge clk);
        soft_a = 1'b1; soft_b = 1'b1;
        @(negedge clk);
        soft_a = 1'b0; soft_b = 1'b0;
        for (int e = 0; e <= 58; e++) begin
            if (e > 0) @(negedge clk);
            ra = rel_vec(n, base_a, 4, 8, 16);
            rb = rel_vec(n, base_b, 1, 1, 1);
            checks++;
            if ({out_a, done_a, busy_a, out_b, done_b, busy_b} !== {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]}) begin
                fails++; $display("FAIL soft_done k+%0d: got %b want %b", e,
                    {out_a, done_a, busy_a, out_b, done_b, busy_b}, {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]});
            end
            if (e == 0 || e == 7 || e == 8 || e == 56) begin
                logic [4:0] lit;
                case (e)
                    0, 7:    lit = 5'b1111_0;
                    8:       lit = 5'b1110_0;
                    default: lit = 5'b0000_1;
                endcase
                checks++;
                if ({out_a, done_a} !== lit) begin
                    fails++; $display("FAIL soft_done_lit k+%0d: got %b want %b", e, {out_a, done_a}, lit);
                end
            end
        end
    endtask

    task automatic test_soft_release();
        @(negedge clk);
        soft_a = 1'b1;
        @(negedge clk);
        soft_a = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (out_a !== 4'b1100) begin
            fails++; $display("FAIL soft_rel_pre: got %b want %b", out_a, 4'b1100);
        end
        soft_a = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if ({out_a, done_a} !== 5'b1111_0) begin
                fails++; $display("FAIL soft_rel_held %0d: got %b want %b", j, {out_a, done_a}, 5'b11110);
            end
        end
        soft_a = 1'b0;
        for (int p = 1; p <= 60; p++) begin
            @(negedge clk);
            ra = rel_vec(n, base_a, 4, 8, 16);
            checks++;
            if ({out_a, done_a, busy_a} !== {~ra, &ra, ~&ra}) begin
                fails++; $display("FAIL soft_rel +%0d: got %b want %b", p, {out_a, done_a, busy_a}, {~ra, &ra, ~&ra});
            end
            if (p == 7 || p == 8) begin
                checks++;
                if (out_a !== ((p == 8) ? 4'b1110 : 4'b1111)) begin
                    fails++; $display("FAIL soft_rel_lit +%0d: got %b", p, out_a);
                end
            end
        end
    endtask

    task automatic test_glitch_sync();
        @(negedge clk);
        soft_a = 1'b1;
        @(negedge clk);
        soft_a = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({out_a, done_a, busy_a, out_b, done_b} !== 8'b1111_01_00) begin
            fails++; $display("FAIL glitch_assert: got %b want %b", {out_a, done_a, busy_a, out_b, done_b}, 8'b11110100);
        end
        rst_in = 1'b1;
        soft_a = 1'b1;  // held through SYNC, must be ignored
        for (int e = 1; e <= 62; e++) begin
            @(negedge clk);
            if (e == 4) soft_a = 1'b0;
            ra = rel_vec(n, base_a, 4, 8, 16);
            checks++;
            if ({out_a, done_a, busy_a} !== {~ra, &ra, ~&ra}) begin
                fails++; $display("FAIL glitch_seq edge %0d: got %b want %b", e, {out_a, done_a, busy_a}, {~ra, &ra, ~&ra});
            end
            if (e == 10 || e == 11) begin
                checks++;
                if (out_a !== ((e == 11) ? 4'b1110 : 4'b1111)) begin
                    fails++; $display("FAIL glitch_lit edge %0d: got %b", e, out_a);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            ra = rel_vec(n, base_a, 4, 8, 16);
            rb = rel_vec(n, base_b, 1, 1, 1);
            checks++;
            if ({out_a, done_a, busy_a, out_b, done_b, busy_b} !== {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]}) begin
                fails++; $display("FAIL random cycle %0d: got %b want %b", c,
                    {out_a, done_a, busy_a, out_b, done_b, busy_b}, {~ra, &ra, ~&ra, rb[0], rb[0], ~rb[0]});
            end
            if (soft_a ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0)) soft_a = ~soft_a;
            if (soft_b ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0)) soft_b = ~soft_b;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_in = 1'b0;
                #1 rst_in = 1'b1;
            end
        end
        soft_a = 1'b0; soft_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_async_in_done();
        test_soft_done();
        test_soft_release();
        test_glitch_sync();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
